// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder, slave response multiplexer and built-in default slave.
// Define AHB_DECODER_ERRLOG_EN to add a sticky log of unmapped-access errors (ERR_VALID/ERR_ADDR/ERR_CLR).
module ahb_decoder_mux #(
  parameter int                             NUM_SLAVES = 3,
  parameter int                             SEL_BITS   = 4,
  parameter logic [NUM_SLAVES*SEL_BITS-1:0] BASE_ADDRS = {4'd3, 4'd2, 4'd1},
  parameter int                             DATA_WIDTH = 32
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [31:0]                      HADDR,
  input  logic [1:0]                       HTRANS,
  output logic [NUM_SLAVES-1:0]            HSEL,
  output logic                             HSEL_DF,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             HREADY,
  output logic                             HRESP
`ifdef AHB_DECODER_ERRLOG_EN
  ,
  input  logic                             ERR_CLR,
  output logic                             ERR_VALID,
  output logic [31:0]                      ERR_ADDR
`endif
);

  localparam int               IDX_W  = $clog2(NUM_SLAVES + 1);
  localparam logic [IDX_W-1:0] DF_IDX = IDX_W'(NUM_SLAVES);

  typedef enum logic [1:0] {DF_OK, DF_ERR1, DF_ERR2} df_state_t;

  df_state_t           state, state_next;
  logic [SEL_BITS-1:0] region;
  logic [IDX_W-1:0]    dec_idx;
  logic [IDX_W-1:0]    dsel;
  logic                dsel_active;
  logic                err_entry;
  logic                df_ready;
  logic                df_resp;
  logic                unused_bits;

  assign region      = HADDR[31 -: SEL_BITS];
  assign unused_bits = ^{HTRANS[0], HADDR[31-SEL_BITS:0]};

  // Address phase: descending scan so the lowest matching index wins
  always_comb begin
    HSEL    = '0;
    dec_idx = DF_IDX;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (region == BASE_ADDRS[i*SEL_BITS +: SEL_BITS]) begin
        HSEL    = '0;
        HSEL[i] = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  assign HSEL_DF = ~|HSEL;

  // Data phase: select register advances only when the bus is ready
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= DF_OK;
      dsel        <= DF_IDX;
      dsel_active <= 1'b0;
    end else begin
      state <= state_next;
      if (HREADY) begin
        dsel        <= dec_idx;
        dsel_active <= HTRANS[1];
      end
    end
  end

  always_comb begin
    state_next = state;
    err_entry  = HREADY & HSEL_DF & HTRANS[1];
    case (state)
      DF_OK:   if (err_entry) state_next = DF_ERR1;
      DF_ERR1: state_next = DF_ERR2;
      DF_ERR2: state_next = err_entry ? DF_ERR1 : DF_OK;
      default: state_next = DF_OK;
    endcase
  end

  // Error states only ever follow an active unmapped transfer, so dsel_active is high there
  assign df_ready = (state != DF_ERR1);
  assign df_resp  = dsel_active & (state != DF_OK);

  always_comb begin
    HRDATA = '0;
    HREADY = df_ready;
    HRESP  = df_resp;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel == IDX_W'(i)) begin
        HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
      end
    end
  end

`ifdef AHB_DECODER_ERRLOG_EN
  // A new error outranks a simultaneous clear
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= '0;
    end else if (state_next == DF_ERR1) begin
      ERR_VALID <= 1'b1;
      ERR_ADDR  <= HADDR;
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Scoreboard bench for ahb_decoder_mux: the stimulus queues expected bus responses per cycle,
// a monitor on the falling edge pops and compares them.
module tb_ahb_decoder_mux;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] NONSEQ = 2'd2;

  localparam logic [4:0] M_SEL  = 5'b00001;
  localparam logic [4:0] M_RDY  = 5'b00010;
  localparam logic [4:0] M_RESP = 5'b00100;
  localparam logic [4:0] M_DATA = 5'b01000;
  localparam logic [4:0] M_LOG  = 5'b10000;
  localparam logic [4:0] M_ALL  = 5'b01111;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSEL;
  logic        HSEL_DF;
  logic [95:0] HRDATA_S;
  logic [2:0]  HREADYOUT_S;
  logic [2:0]  HRESP_S;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
`ifdef AHB_DECODER_ERRLOG_EN
  logic        ERR_CLR;
  logic        ERR_VALID;
  logic [31:0] ERR_ADDR;
  logic        nxt_clr;
`endif

  ahb_decoder_mux dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL(HSEL), .HSEL_DF(HSEL_DF),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
`ifdef AHB_DECODER_ERRLOG_EN
    , .ERR_CLR(ERR_CLR), .ERR_VALID(ERR_VALID), .ERR_ADDR(ERR_ADDR)
`endif
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    logic [4:0]  mask;
    logic [2:0]  hsel;
    logic        df;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    logic        ev;
    logic [31:0] ea;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  logic        nxt_rst;
  logic [2:0]  nxt_rdyo;
  logic [2:0]  nxt_resps;
  logic [31:0] nxt_d2;
  logic        exp_ev;
  logic [31:0] exp_ea;

  task automatic chk(input string n, input string f, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s.%s got=%0h want=%0h", n, f, got, want);
    end
  endtask

  // One bus cycle: apply inputs just after the edge and queue what the outputs must show
  task automatic cyc(input string n, input logic [31:0] addr, input logic [1:0] trans,
                     input logic [4:0] mask, input logic [2:0] hsel, input logic df,
                     input logic rdy, input logic resp, input logic [31:0] rdata);
    exp_t e;
    @(posedge HCLK);
    #1;
    HRESET      = nxt_rst;
    HADDR       = addr;
    HTRANS      = trans;
    HREADYOUT_S = nxt_rdyo;
    HRESP_S     = nxt_resps;
    HRDATA_S    = {nxt_d2, 32'hBBBB_0001, 32'hAAAA_0000};
`ifdef AHB_DECODER_ERRLOG_EN
    ERR_CLR     = nxt_clr;
`endif
    e.name = n; e.mask = mask; e.hsel = hsel; e.df = df; e.rdy = rdy;
    e.resp = resp; e.rdata = rdata; e.ev = exp_ev; e.ea = exp_ea;
    q.push_back(e);
  endtask

  always @(negedge HCLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.mask[0]) chk(e.name, "hsel_df", 32'({HSEL_DF, HSEL}), 32'({e.df, e.hsel}));
      if (e.mask[1]) chk(e.name, "hready", 32'(HREADY), 32'(e.rdy));
      if (e.mask[2]) chk(e.name, "hresp", 32'(HRESP), 32'(e.resp));
      if (e.mask[3]) chk(e.name, "hrdata", HRDATA, e.rdata);
`ifdef AHB_DECODER_ERRLOG_EN
      if (e.mask[4]) begin
        chk(e.name, "err_valid", 32'(ERR_VALID), 32'(e.ev));
        chk(e.name, "err_addr", ERR_ADDR, e.ea);
      end
`endif
    end
  end

  function automatic logic [2:0] dec(input logic [3:0] c);
    case (c)
      4'd1:    return 3'b001;
      4'd2:    return 3'b010;
      4'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] data_of(input logic [3:0] c);
    case (c)
      4'd1:    return 32'hAAAA_0000;
      4'd2:    return 32'hBBBB_0001;
      4'd3:    return 32'hCCCC_0002;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    logic [3:0] prev;
    HRESET = 1'b1; HADDR = '0; HTRANS = IDLE;
    HREADYOUT_S = 3'b111; HRESP_S = '0; HRDATA_S = '0;
    nxt_rst = 1'b1; nxt_rdyo = 3'b111; nxt_resps = '0; nxt_d2 = 32'hCCCC_0002;
    exp_ev = 1'b0; exp_ea = '0;
`ifdef AHB_DECODER_ERRLOG_EN
    ERR_CLR = 1'b0; nxt_clr = 1'b0;
`endif

    // Reset
    cyc("rst0", 32'h2000_0000, IDLE, M_SEL, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc("rst1", 32'h2000_0000, IDLE, M_ALL | M_LOG, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0);
    nxt_rst = 1'b0;
    cyc("rst2", 32'h2000_0000, IDLE, M_ALL | M_LOG, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0);

    // Decode sweep with IDLE: data lags one cycle behind the decode
    prev = 4'd2;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] code;
      code = 4'(c);
      cyc($sformatf("sweep%0d", c), {code, 28'h0}, IDLE, M_ALL,
          dec(code), (dec(code) == 3'b000), 1'b1, 1'b0, data_of(prev));
      prev = code;
    end

    // Mux and slave wait states
    cyc("a_nonseq", 32'h3000_0010, NONSEQ, M_ALL, 3'b100, 1'b0, 1'b1, 1'b0, 32'h0);
    nxt_rdyo = 3'b011; nxt_d2 = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++)
      cyc($sformatf("stall%0d", k), 32'h1000_0000, NONSEQ, M_ALL, 3'b001, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    nxt_rdyo = 3'b111;
    cyc("ready", 32'h1000_0000, NONSEQ, M_ALL, 3'b001, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    nxt_d2 = 32'hCCCC_0002;
    cyc("switch", 32'h2000_0000, IDLE, M_ALL, 3'b010, 1'b0, 1'b1, 1'b0, 32'hAAAA_0000);

    // Single unmapped error
    cyc("e_addr", 32'hF000_0000, NONSEQ, M_ALL, 3'b000, 1'b1, 1'b1, 1'b0, 32'hBBBB_0001);
    exp_ev = 1'b1; exp_ea = 32'hF000_0000;
    cyc("e_err1", 32'h2000_0000, IDLE, M_ALL | M_LOG, 3'b010, 1'b0, 1'b0, 1'b1, 32'h0);
    cyc("e_err2", 32'h2000_0000, IDLE, M_ALL, 3'b010, 1'b0, 1'b1, 1'b1, 32'h0);
    cyc("e_ok", 32'h2000_0000, IDLE, M_ALL, 3'b010, 1'b0, 1'b1, 1'b0, 32'hBBBB_0001);

    // Back-to-back errors
    cyc("f_addr1", 32'hF000_0000, NONSEQ, M_ALL, 3'b000, 1'b1, 1'b1, 1'b0, 32'hBBBB_0001);
    cyc("f_err1a", 32'hE000_0000, NONSEQ, M_ALL, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0);
    cyc("f_err2a", 32'hE000_0000, NONSEQ, M_ALL, 3'b000, 1'b1, 1'b1, 1'b1, 32'h0);
    exp_ea = 32'hE000_0000;
    cyc("f_err1b", 32'h1000_0000, IDLE, M_ALL | M_LOG, 3'b001, 1'b0, 1'b0, 1'b1, 32'h0);
    cyc("f_err2b", 32'h1000_0000, IDLE, M_ALL, 3'b001, 1'b0, 1'b1, 1'b1, 32'h0);
    cyc("f_ok", 32'h1000_0000, IDLE, M_ALL, 3'b001, 1'b0, 1'b1, 1'b0, 32'hAAAA_0000);

    // Reset during the first error cycle
    cyc("g_addr", 32'hD000_0000, NONSEQ, M_ALL, 3'b000, 1'b1, 1'b1, 1'b0, 32'hAAAA_0000);
    nxt_rst = 1'b1; exp_ea = 32'hD000_0000;
    cyc("g_err1_rst", 32'hD000_0000, NONSEQ, M_ALL | M_LOG, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0);
    nxt_rst = 1'b0; exp_ev = 1'b0; exp_ea = 32'h0;
    cyc("g_after_rst", 32'h3000_0000, IDLE, M_ALL | M_LOG, 3'b100, 1'b0, 1'b1, 1'b0, 32'h0);
    nxt_resps = 3'b100;
    cyc("g_slv_err", 32'h3000_0000, IDLE, M_ALL, 3'b100, 1'b0, 1'b1, 1'b1, 32'hCCCC_0002);
    nxt_resps = 3'b000;
    cyc("g_slv_ok", 32'h3000_0000, IDLE, M_ALL, 3'b100, 1'b0, 1'b1, 1'b0, 32'hCCCC_0002);

`ifdef AHB_DECODER_ERRLOG_EN
    // Error log capture, overwrite, and set-beats-clear
    cyc("h_addr", 32'h8000_0004, NONSEQ, M_ALL | M_LOG, 3'b000, 1'b1, 1'b1, 1'b0, 32'hCCCC_0002);
    exp_ev = 1'b1; exp_ea = 32'h8000_0004;
    cyc("h_err1", 32'h9000_0000, NONSEQ, M_ALL | M_LOG, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0);
    nxt_clr = 1'b1;
    cyc("h_err2_clr", 32'h9000_0000, NONSEQ, M_ALL | M_LOG, 3'b000, 1'b1, 1'b1, 1'b1, 32'h0);
    nxt_clr = 1'b0; exp_ea = 32'h9000_0000;
    cyc("h_err1_b", 32'h1000_0000, IDLE, M_ALL | M_LOG, 3'b001, 1'b0, 1'b0, 1'b1, 32'h0);
    cyc("h_err2_b", 32'h1000_0000, IDLE, M_ALL | M_LOG, 3'b001, 1'b0, 1'b1, 1'b1, 32'h0);
    nxt_clr = 1'b1;
    cyc("h_clr", 32'h1000_0000, IDLE, M_ALL | M_LOG, 3'b001, 1'b0, 1'b1, 1'b0, 32'hAAAA_0000);
    nxt_clr = 1'b0; exp_ev = 1'b0;
    cyc("h_cleared", 32'h1000_0000, IDLE, M_ALL | M_LOG, 3'b001, 1'b0, 1'b1, 1'b0, 32'hAAAA_0000);
`endif

    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      @(negedge HCLK);
      #1;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
